gcd_dispatch_ctrl: RTL and testbench

//   Scheduler for the 4-way 2-bit-select demux feeding four GCD worker units.

---
 rtl/gcd_pkg.sv | 26 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/gcd_dispatch_ctrl.sv | 115 +++++++++++
 tb/tb_gcd_dispatch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD worker dispatch controller: worker count, worker index
// and the two-state dispatch FSM encoding.
package gcd_pkg;

  localparam int NUM_WORKERS = 4;

  typedef logic [1:0] worker_idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dispatch_state_t;

  function automatic logic [NUM_WORKERS-1:0] worker_onehot(input worker_idx_t idx);
    logic [NUM_WORKERS-1:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin idle-worker picker: first non-busy worker after rr_ptr, wrapping 3->0.
module rr_pick4
  import gcd_pkg::*;
(
  input  logic [NUM_WORKERS-1:0] busy,
  input  worker_idx_t            rr_ptr,
  output worker_idx_t            pick,
  output logic                   any_free
);

  worker_idx_t cand_s;
  logic        found_s;

  // Scan rr_ptr+1 .. rr_ptr+4 and keep the first idle candidate.
  always_comb begin
    pick    = rr_ptr + 2'd1;
    found_s = 1'b0;
    cand_s  = rr_ptr;
    for (int k = 1; k <= NUM_WORKERS; k++) begin
      cand_s = rr_ptr + worker_idx_t'(k);
      if (!found_s && !busy[cand_s]) begin
        pick    = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any_free = ~&busy;
  end

endmodule

// File: rtl/gcd_dispatch_ctrl.sv
// Dispatch controller for four GCD workers behind a 2-bit demux: round-robin issue,
// one-cycle start strobe, per-worker busy tracking. GCD_DISPATCH_STATS_EN adds counters.
module gcd_dispatch_ctrl
  import gcd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_op_a,
  input  logic [DATA_W-1:0]      in_op_b,
  output worker_idx_t            sel,
  output logic                   start,
  output logic [DATA_W-1:0]      op_a_q,
  output logic [DATA_W-1:0]      op_b_q,
  input  logic [NUM_WORKERS-1:0] worker_done,
  output logic [NUM_WORKERS-1:0] busy
`ifdef GCD_DISPATCH_STATS_EN
  ,
  output logic [15:0]            jobs_issued,
  output logic                   spurious_done
`endif
);

  dispatch_state_t        state_r;
  worker_idx_t            rr_ptr_r;
  worker_idx_t            pick_s;
  logic                   any_free_s;
  logic                   accept_s;
  logic [NUM_WORKERS-1:0] grant_s;
  logic [NUM_WORKERS-1:0] busy_nxt_s;

  rr_pick4 u_pick (
    .busy     (busy),
    .rr_ptr   (rr_ptr_r),
    .pick     (pick_s),
    .any_free (any_free_s)
  );

  // Handshake and next busy vector; done on an idle worker is a no-op by construction.
  always_comb begin
    accept_s   = (state_r == IDLE) && in_valid && in_ready && any_free_s;
    grant_s    = accept_s ? worker_onehot(pick_s) : 4'b0000;
    busy_nxt_s = (busy & ~worker_done) | grant_s;
  end

  // Dispatch FSM; in_ready is registered from the next-cycle state and busy vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= 2'd3;
      busy     <= 4'b0000;
      sel      <= 2'd0;
      start    <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      busy <= busy_nxt_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r  <= ISSUE;
            sel      <= pick_s;
            rr_ptr_r <= pick_s;
            op_a_q   <= in_op_a;
            op_b_q   <= in_op_b;
            start    <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            start    <= 1'b0;
            in_ready <= ~&busy_nxt_s;
          end
        end
        ISSUE: begin
          state_r  <= IDLE;
          start    <= 1'b0;
          in_ready <= ~&busy_nxt_s;
        end
        default: begin
          state_r  <= IDLE;
          start    <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef GCD_DISPATCH_STATS_EN
  logic spurious_s;

  // Done pulses that arrive for an idle worker.
  always_comb begin
    spurious_s = |(worker_done & ~busy);
  end

  // Issue counter (wraps naturally) and sticky spurious-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jobs_issued   <= 16'h0000;
      spurious_done <= 1'b0;
    end else begin
      if (accept_s) begin
        jobs_issued <= jobs_issued + 16'd1;
      end else begin
        jobs_issued <= jobs_issued;
      end
      spurious_done <= spurious_done | spurious_s;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_dispatch_ctrl.sv
// Self-checking bench for gcd_dispatch_ctrl: job-level model compared every cycle plus
// directed scenarios with literal expectations.
module tb_gcd_dispatch_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_op_a = '0;
  logic [DW-1:0] in_op_b = '0;
  logic [1:0]    sel;
  logic          start;
  logic [DW-1:0] op_a_q;
  logic [DW-1:0] op_b_q;
  logic [3:0]    worker_done = 4'b0000;
  logic [3:0]    busy;
`ifdef GCD_DISPATCH_STATS_EN
  logic [15:0]   jobs_issued;
  logic          spurious_done;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Job-level model: which workers hold a job, who got the last grant, pending strobe.
  logic [3:0]    m_busy = 4'b0000;
  int            m_last = 3;
  bit            m_issue = 1'b0;
  logic [1:0]    m_sel = 2'd0;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;

  int st_sel[$];
  int st_cyc[$];

  gcd_dispatch_ctrl #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op_a     (in_op_a),
    .in_op_b     (in_op_b),
    .sel         (sel),
    .start       (start),
    .op_a_q      (op_a_q),
    .op_b_q      (op_b_q),
    .worker_done (worker_done),
    .busy        (busy)
`ifdef GCD_DISPATCH_STATS_EN
    ,
    .jobs_issued   (jobs_issued),
    .spurious_done (spurious_done)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] nb;
    bit         acc;
    bit         found;
    int         w;
    if (!rst_n) begin
      m_busy  = 4'b0000;
      m_last  = 3;
      m_issue = 1'b0;
      m_sel   = 2'd0;
      m_a     = '0;
      m_b     = '0;
    end else begin
      nb    = m_busy & ~worker_done;
      acc   = !m_issue && (m_busy != 4'hF) && in_valid;
      found = 1'b0;
      if (acc) begin
        for (int k = 1; k <= 4; k++) begin
          w = (m_last + k) % 4;
          if (!found && !m_busy[w]) begin
            found  = 1'b1;
            nb[w]  = 1'b1;
            m_last = w;
            m_sel  = 2'(w);
            m_a    = in_op_a;
            m_b    = in_op_b;
          end
        end
      end
      m_busy  = nb;
      m_issue = acc;
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, (!m_issue && (m_busy != 4'hF))});
    check("start", {31'd0, start}, {31'd0, m_issue});
    check("sel", {30'd0, sel}, {30'd0, m_sel});
    check("busy", {28'd0, busy}, {28'd0, m_busy});
    if (m_issue) begin
      check("op_a_q", {24'd0, op_a_q}, {24'd0, m_a});
      check("op_b_q", {24'd0, op_b_q}, {24'd0, m_b});
    end
    if (start === 1'b1) begin
      st_sel.push_back(int'(sel));
      st_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_job(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit rdy;
    in_valid = 1'b1;
    in_op_a  = a;
    in_op_b  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    n_bad++;
    $display("FAIL send_job: no accept within 50 cycles, got in_ready=0, expected 1");
  endtask

  task automatic pulse_done(input logic [3:0] mask);
    worker_done = mask;
    tick();
    worker_done = 4'b0000;
  endtask

  initial begin : stim
    int rel_cyc;
    int dc;
    int sc;
    bit seen;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rel_cyc = cyc;
    check("reset_busy", {28'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, in_ready}, 32'd1);

    // Four back-to-back jobs fill workers 0..3 in order, one start every two cycles.
    st_sel.delete();
    st_cyc.delete();
    for (int i = 0; i < 4; i++) send_job(8'(i + 1), 8'(i + 11));
    tick();
    tick();
    check("t1_starts", st_sel.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < st_sel.size()) begin
        check("t1_sel", st_sel[i], i);
        check("t1_cycle", st_cyc[i] - rel_cyc, 1 + 2 * i);
      end
    end
    check("t1_busy", {28'd0, busy}, 32'hF);
    check("t1_ready", {31'd0, in_ready}, 32'd0);

    // Freeing worker 2 while a job waits: it is re-issued to worker 2.
    in_valid = 1'b1;
    in_op_a  = 8'd7;
    in_op_b  = 8'd3;
    tick();
    worker_done = 4'b0100;
    dc = cyc;
    tick();
    worker_done = 4'b0000;
    seen = 1'b0;
    sc = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin
        seen = 1'b1;
        sc = cyc;
        check("t2_sel", {30'd0, sel}, 32'd2);
      end
    end
    in_valid = 1'b0;
    check("t2_seen", {31'd0, seen}, 32'd1);
    check("t2_latency", sc - dc, 32'd2);
    tick();
    tick();
    check("t2_busy", {28'd0, busy}, 32'hF);

    // Move the pointer to 1, leave busy=1010, then check the 2 and wrap-to-0 grants.
    pulse_done(4'b0010);
    send_job(8'd1, 8'd1);
    check("t3_sel1", {30'd0, sel}, 32'd1);
    tick();
    pulse_done(4'b0101);
    check("t3_busy", {28'd0, busy}, 32'hA);
    send_job(8'd48, 8'd18);
    check("t3_sel2", {30'd0, sel}, 32'd2);
    check("t4_start", {31'd0, start}, 32'd1);
    check("t4_op_a", {24'd0, op_a_q}, 32'd48);
    check("t4_op_b", {24'd0, op_b_q}, 32'd18);
    tick();
    send_job(8'd5, 8'd9);
    check("t3_sel_wrap", {30'd0, sel}, 32'd0);
    tick();

    // Reset asserted while the strobe is high.
    pulse_done(4'b1000);
    send_job(8'd9, 8'd3);
    check("t5_start_pre", {31'd0, start}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_start_rst", {31'd0, start}, 32'd0);
    check("t5_busy_rst", {28'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    send_job(8'd2, 8'd2);
    check("t5_sel_after", {30'd0, sel}, 32'd0);
    tick();

    // Done on an idle worker changes nothing.
    pulse_done(4'b0010);
    check("spurious_busy", {28'd0, busy}, 32'd1);

`ifdef GCD_DISPATCH_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done(4'b0010);
    check("t6_spurious", {31'd0, spurious_done}, 32'd1);
    check("t6_busy", {28'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) send_job(8'(i), 8'(i));
    tick();
    pulse_done(4'b0001);
    send_job(8'd6, 8'd4);
    tick();
    check("t6_jobs", {16'd0, jobs_issued}, 32'd5);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
